// File: rtl/can_bit_timing_rx.sv
// can_bit_timing_rx: receive-side CAN bit timing unit.
// Synchronizes the raw RX line, divides clk into time quanta, walks
// SYNC_SEG -> TSEG1 -> TSEG2 and emits the sample strobe, the TX bit-boundary
// strobe and resync events. Hard sync and SJW-limited resync realign the bit
// to recessive-to-dominant bus edges.
// Optional build macro: CAN_TRIPLE_SAMPLE_EN selects majority-of-three
// sampling on the last three tq of TSEG1 instead of a single sample.
// seg_state exposes the segment FSM state directly.
module can_bit_timing_rx #(
  parameter int TQ_DIV = 4,
  parameter int TSEG1  = 6,
  parameter int TSEG2  = 3,
  parameter int SJW    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       hard_sync_en,
  output logic       sample_valid,
  output logic       sample_bit,
  output logic       tx_point,
  output logic       resync_evt,
  output logic [1:0] seg_state
);

  localparam int PS_W  = $clog2(TQ_DIV);
  localparam int CNT_W = $clog2(TSEG1 + SJW + 1);

  typedef enum logic [1:0] {
    SEG_SYNC  = 2'd0,
    SEG_TSEG1 = 2'd1,
    SEG_TSEG2 = 2'd2
  } seg_t;

  logic             rx_meta, rx_s, prev_rx;
  seg_t             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic [CNT_W-1:0] ext_q, ext_d;
  logic [CNT_W-1:0] shr_q, shr_d;
  logic             done_q, done_d;
  logic             sv_q, sv_d, sb_q, sb_d, tx_q, tx_d, evt_q, evt_d;

  logic tq_tick, edge_det, tseg1_end, tseg2_end, sample_pt, eff_tseg2;
  logic sample_val;
  int   tseg1_len, tseg2_len, e_tseg1, e_tseg2;

  assign tq_tick   = (ps_q == PS_W'(TQ_DIV - 1));
  assign edge_det  = prev_rx & ~rx_s;
  assign tseg1_len = TSEG1 + int'(ext_q);
  assign tseg2_len = TSEG2 - int'(shr_q);
  assign tseg1_end = (state_q == SEG_TSEG1) && (int'(cnt_q) == tseg1_len - 1);
  // >= so that a shortening applied late in TSEG2 ends it at the next tick.
  assign tseg2_end = (state_q == SEG_TSEG2) && (int'(cnt_q) >= tseg2_len - 1);
  assign sample_pt = tq_tick && tseg1_end;
  // An edge on the sample-point tick counts as a TSEG2 edge at seg_cnt 0.
  assign eff_tseg2 = (state_q == SEG_TSEG2) || sample_pt;
  assign e_tseg1   = int'(cnt_q) + 1;
  assign e_tseg2   = (state_q == SEG_TSEG2) ? (TSEG2 - int'(cnt_q)) : TSEG2;

`ifdef CAN_TRIPLE_SAMPLE_EN
  logic cap0_q, cap0_d, cap1_q, cap1_d;

  assign sample_val = (cap0_q & cap1_q) | (cap0_q & rx_s) | (cap1_q & rx_s);

  // Capture rx_s on the two tq ticks before the sample point.
  always_comb begin
    cap0_d = cap0_q;
    cap1_d = cap1_q;
    if (tq_tick && state_q == SEG_TSEG1) begin
      if (int'(cnt_q) == tseg1_len - 3) cap0_d = rx_s;
      if (int'(cnt_q) == tseg1_len - 2) cap1_d = rx_s;
    end
  end

  // Early-capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap0_q <= 1'b1;
      cap1_q <= 1'b1;
    end else begin
      cap0_q <= cap0_d;
      cap1_q <= cap1_d;
    end
  end
`else
  assign sample_val = rx_s;
`endif

  // Next-state logic: tq-driven segment walk, then edge handling on top.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ps_d    = tq_tick ? '0 : ps_q + PS_W'(1);
    ext_d   = ext_q;
    shr_d   = shr_q;
    done_d  = done_q;
    sv_d    = 1'b0;
    sb_d    = sb_q;
    tx_d    = 1'b0;
    evt_d   = 1'b0;

    if (tq_tick) begin
      case (state_q)
        SEG_SYNC: begin
          state_d = SEG_TSEG1;
          cnt_d   = '0;
        end
        SEG_TSEG1: begin
          if (tseg1_end) begin
            state_d = SEG_TSEG2;
            cnt_d   = '0;
            sv_d    = 1'b1;
            sb_d    = sample_val;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        SEG_TSEG2: begin
          if (tseg2_end) begin
            state_d = SEG_SYNC;
            cnt_d   = '0;
            tx_d    = 1'b1;
            ext_d   = '0;
            shr_d   = '0;
            done_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = SEG_SYNC;
          cnt_d   = '0;
        end
      endcase
    end

    if (edge_det) begin
      if (hard_sync_en) begin
        // Hard sync restarts the bit after SYNC_SEG and wins over any tick.
        state_d = SEG_TSEG1;
        cnt_d   = '0;
        ps_d    = '0;
        ext_d   = '0;
        shr_d   = '0;
        done_d  = 1'b1;
        evt_d   = 1'b1;
        sv_d    = 1'b0;
        sb_d    = sb_q;
        tx_d    = 1'b0;
      end else if (!done_q && sb_q) begin
        done_d = 1'b1;
        evt_d  = 1'b1;
        if (eff_tseg2) begin
          if (e_tseg2 <= SJW) begin
            // Edge is the new sync point: start the next bit's TSEG1 now.
            state_d = SEG_TSEG1;
            cnt_d   = '0;
            ps_d    = '0;
            ext_d   = '0;
            shr_d   = '0;
            tx_d    = 1'b1;
          end else begin
            shr_d = CNT_W'(SJW);
          end
        end else if (state_q == SEG_TSEG1) begin
          ext_d = (e_tseg1 < SJW) ? CNT_W'(e_tseg1) : CNT_W'(SJW);
        end
      end
    end
  end

  // Synchronizer, edge history and FSM/output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      prev_rx <= 1'b1;
      state_q <= SEG_SYNC;
      cnt_q   <= '0;
      ps_q    <= '0;
      ext_q   <= '0;
      shr_q   <= '0;
      done_q  <= 1'b0;
      sv_q    <= 1'b0;
      sb_q    <= 1'b1;
      tx_q    <= 1'b0;
      evt_q   <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      prev_rx <= rx_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ps_q    <= ps_d;
      ext_q   <= ext_d;
      shr_q   <= shr_d;
      done_q  <= done_d;
      sv_q    <= sv_d;
      sb_q    <= sb_d;
      tx_q    <= tx_d;
      evt_q   <= evt_d;
    end
  end

  assign sample_valid = sv_q;
  assign sample_bit   = sb_q;
  assign tx_point     = tx_q;
  assign resync_evt   = evt_q;
  assign seg_state    = state_q;

endmodule
